// File: rtl/pattern_pkg.sv
// Shared types and constants for the video test-pattern generator.
// Holds pattern modes, tint encodings, LFSR constants and line-scaling helper.
package pattern_pkg;

  typedef enum logic [1:0] {
    NOISE = 2'd0,
    BARS  = 2'd1,
    GRID  = 2'd2,
    SOLID = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    COL_WHITE = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } col_t;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]  LVL_ON    = 8'hFF;

  // Channel enables as {r, g, b}
  function automatic logic [2:0] col_mask(input col_t c);
    logic [2:0] m;
    unique case (c)
      COL_WHITE: m = 3'b111;
      COL_RED:   m = 3'b100;
      COL_GREEN: m = 3'b010;
      COL_BLUE:  m = 3'b001;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic int unsigned vscale(input int unsigned lines, input logic sd);
    return sd ? lines * 2 : lines;
  endfunction

endpackage

// File: rtl/video_counter.sv
// Pixel-enable divider, horizontal/vertical/frame counters and timing strobes.
// PAL and scandouble are latched at frame start and govern the whole frame.
module video_counter
  import pattern_pkg::*;
#(
  parameter int unsigned CE_DIV       = 4,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 280,
  parameter int unsigned H_SYNC_END   = 304,
  parameter int unsigned H_TOTAL      = 320,
  parameter int unsigned V_ACTIVE_N   = 240,
  parameter int unsigned V_TOTAL_N    = 262,
  parameter int unsigned V_ACTIVE_P   = 288,
  parameter int unsigned V_TOTAL_P    = 312,
  parameter int unsigned V_SYNC_OFS   = 4,
  parameter int unsigned V_SYNC_LEN   = 3,
  parameter int unsigned CW           = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pal_i,
  input  logic          scandouble_i,
  output logic          ce_pix_o,
  output logic          frame_wrap_o,
  output logic          hblank_o,
  output logic          hsync_o,
  output logic          vblank_o,
  output logic          vsync_o,
  output logic [CW-1:0] hc_o,
  output logic [CW-1:0] vc_o,
  output logic [7:0]    frame_o
);

  localparam int unsigned DivW = $clog2(CE_DIV);

  logic [DivW-1:0] div_q, div_d, div_last;
  logic            ce_q, ce_d;
  logic            pal_q, pal_d, sd_q, sd_d;
  logic [CW-1:0]   hc_q, hc_d, vc_q, vc_d, vt_last;
  logic [CW-1:0]   va_nxt, vss_nxt, vse_nxt;
  logic [7:0]      frame_q, frame_d;
  logic            hblank_q, hblank_d, hsync_q, hsync_d;
  logic            vblank_q, vblank_d, vsync_q, vsync_d;
  logic            h_wrap, v_wrap, frame_wrap;

  always_comb begin
    div_last   = sd_q ? DivW'(CE_DIV / 2 - 1) : DivW'(CE_DIV - 1);
    vt_last    = CW'(vscale(pal_q ? V_TOTAL_P : V_TOTAL_N, sd_q) - 1);
    h_wrap     = (hc_q == CW'(H_TOTAL - 1));
    v_wrap     = (vc_q == vt_last);
    frame_wrap = ce_q & h_wrap & v_wrap;

    div_d   = (div_q >= div_last) ? '0 : div_q + DivW'(1);
    ce_d    = (div_q == div_last);
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;
    pal_d   = pal_q;
    sd_d    = sd_q;

    if (ce_q) begin
      hc_d = h_wrap ? '0 : hc_q + CW'(1);
      if (h_wrap) vc_d = v_wrap ? '0 : vc_q + CW'(1);
      if (frame_wrap) begin
        frame_d = frame_q + 8'd1;
        pal_d   = pal_i;
        sd_d    = scandouble_i;
      end
    end

    // Strobes follow the next counter values under the settings of their frame
    va_nxt   = CW'(vscale(pal_d ? V_ACTIVE_P : V_ACTIVE_N, sd_d));
    vss_nxt  = CW'(vscale((pal_d ? V_ACTIVE_P : V_ACTIVE_N) + V_SYNC_OFS, sd_d));
    vse_nxt  = CW'(vscale((pal_d ? V_ACTIVE_P : V_ACTIVE_N) + V_SYNC_OFS + V_SYNC_LEN, sd_d));
    hblank_d = (hc_d >= CW'(H_ACTIVE));
    hsync_d  = (hc_d >= CW'(H_SYNC_START)) && (hc_d < CW'(H_SYNC_END));
    vblank_d = (vc_d >= va_nxt);
    vsync_d  = (vc_d >= vss_nxt) && (vc_d < vse_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      ce_q     <= 1'b0;
      pal_q    <= 1'b0;
      sd_q     <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      frame_q  <= '0;
      hblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      ce_q     <= ce_d;
      pal_q    <= pal_d;
      sd_q     <= sd_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      frame_q  <= frame_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
    end
  end

  assign ce_pix_o     = ce_q;
  assign frame_wrap_o = frame_wrap;
  assign hblank_o     = hblank_q;
  assign hsync_o      = hsync_q;
  assign vblank_o     = vblank_q;
  assign vsync_o      = vsync_q;
  assign hc_o         = hc_q;
  assign vc_o         = vc_q;
  assign frame_o      = frame_q;

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator: noise, colour bars, grid or solid fill.
// Mode and tint are latched at frame start; colour lags hc/vc by one pixel.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int unsigned CE_DIV       = 4,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 280,
  parameter int unsigned H_SYNC_END   = 304,
  parameter int unsigned H_TOTAL      = 320,
  parameter int unsigned V_ACTIVE_N   = 240,
  parameter int unsigned V_TOTAL_N    = 262,
  parameter int unsigned V_ACTIVE_P   = 288,
  parameter int unsigned V_TOTAL_P    = 312,
  parameter int unsigned V_SYNC_OFS   = 4,
  parameter int unsigned V_SYNC_LEN   = 3,
  parameter int unsigned CW           = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pal,
  input  logic          scandouble,
  input  logic [1:0]    mode,
  input  logic [1:0]    col,
  output logic          ce_pix,
  output logic          HBlank,
  output logic          HSync,
  output logic          VBlank,
  output logic          VSync,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [7:0]    frame,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
);

  logic        frame_wrap;
  mode_t       mode_q, mode_d;
  col_t        col_q, col_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]  level;
  logic [2:0]  mask, bar_col;
  int unsigned bar_idx;

  video_counter #(
    .CE_DIV      (CE_DIV),
    .H_ACTIVE    (H_ACTIVE),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_END  (H_SYNC_END),
    .H_TOTAL     (H_TOTAL),
    .V_ACTIVE_N  (V_ACTIVE_N),
    .V_TOTAL_N   (V_TOTAL_N),
    .V_ACTIVE_P  (V_ACTIVE_P),
    .V_TOTAL_P   (V_TOTAL_P),
    .V_SYNC_OFS  (V_SYNC_OFS),
    .V_SYNC_LEN  (V_SYNC_LEN),
    .CW          (CW)
  ) u_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .pal_i       (pal),
    .scandouble_i(scandouble),
    .ce_pix_o    (ce_pix),
    .frame_wrap_o(frame_wrap),
    .hblank_o    (HBlank),
    .hsync_o     (HSync),
    .vblank_o    (VBlank),
    .vsync_o     (VSync),
    .hc_o        (hc),
    .vc_o        (vc),
    .frame_o     (frame)
  );

  always_comb begin
    mode_d = mode_q;
    col_d  = col_q;
    lfsr_d = lfsr_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    if (frame_wrap) begin
      mode_d = mode_t'(mode);
      col_d  = col_t'(col);
    end

    bar_idx = (32'(hc) * 32'd8) / H_ACTIVE;
    // Bars run white to black left to right
    bar_col = 3'd7 - 3'(bar_idx);
    level   = LVL_ON;
    mask    = col_mask(col_q);
    unique case (mode_q)
      NOISE: level = lfsr_q[7:0];
      BARS:  mask  = bar_col;
      GRID:  mask  = ((hc[3:0] == 4'd0) || (vc[3:0] == 4'd0)) ? 3'b111 : 3'b000;
      SOLID: mask  = col_mask(col_q);
    endcase

    if (ce_pix) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (HBlank || VBlank) begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end else begin
        r_d = mask[2] ? level : 8'h00;
        g_d = mask[1] ? level : 8'h00;
        b_d = mask[0] ? level : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= NOISE;
      col_q  <= COL_WHITE;
      lfsr_q <= LFSR_SEED;
      r_q    <= 8'h00;
      g_q    <= 8'h00;
      b_q    <= 8'h00;
    end else begin
      mode_q <= mode_d;
      col_q  <= col_d;
      lfsr_q <= lfsr_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen using a shrunken raster so whole frames fit.
// Raster: 40 px/line (32 active), NTSC 14 lines (10 active), PAL 18 (12 active).
module tb_pattern_gen;

  localparam int unsigned CE  = 4;
  localparam int unsigned HA  = 32;
  localparam int unsigned HSS = 34;
  localparam int unsigned HSE = 37;
  localparam int unsigned HT  = 40;
  localparam int unsigned VAN = 10;
  localparam int unsigned VTN = 14;
  localparam int unsigned VAP = 12;
  localparam int unsigned VTP = 18;
  localparam int unsigned VSO = 1;
  localparam int unsigned VSL = 2;
  localparam int unsigned CW  = 10;

  logic          clk, reset_n, pal, scandouble;
  logic [1:0]    mode, col;
  logic          ce_pix, HBlank, HSync, VBlank, VSync;
  logic [CW-1:0] hc, vc;
  logic [7:0]    frame, r, g, b;

  int total = 0;
  int bad   = 0;

  pattern_gen #(
    .CE_DIV      (CE),
    .H_ACTIVE    (HA),
    .H_SYNC_START(HSS),
    .H_SYNC_END  (HSE),
    .H_TOTAL     (HT),
    .V_ACTIVE_N  (VAN),
    .V_TOTAL_N   (VTN),
    .V_ACTIVE_P  (VAP),
    .V_TOTAL_P   (VTP),
    .V_SYNC_OFS  (VSO),
    .V_SYNC_LEN  (VSL),
    .CW          (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pal       (pal),
    .scandouble(scandouble),
    .mode      (mode),
    .col       (col),
    .ce_pix    (ce_pix),
    .HBlank    (HBlank),
    .HSync     (HSync),
    .VBlank    (VBlank),
    .VSync     (VSync),
    .hc        (hc),
    .vc        (vc),
    .frame     (frame),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic wait_frame_change(output bit ok);
    logic [7:0] f0;
    f0 = frame;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame != f0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Walks one frame from its first negedge; tallies strobe disagreements.
  task automatic scan_frame(input int va, input int vss, input int vse, output int clks,
                            output int ces, output int maxv, output int vsmin,
                            output int vsmax, output int errs, output bit ok);
    logic [7:0] f0;
    f0 = frame;
    clks = 0; ces = 0; maxv = 0; vsmin = -1; vsmax = -1; errs = 0; ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      clks++;
      if (frame != f0) begin
        ok = 1;
        break;
      end
      if (ce_pix) ces++;
      if (int'(vc) > maxv) maxv = int'(vc);
      if (VSync) begin
        if (vsmin < 0) vsmin = int'(vc);
        vsmax = int'(vc);
      end
      if (HBlank !== (hc >= HA) || HSync !== (hc >= HSS && hc < HSE) ||
          VBlank !== (int'(vc) >= va) || VSync !== (int'(vc) >= vss && int'(vc) < vse))
        errs++;
    end
  endtask

  task automatic pix_at(input int v, input int h, output logic [23:0] rgb, output bit ok);
    ok = 0;
    rgb = '0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (ce_pix && int'(vc) == v && int'(hc) == h) begin
        @(negedge clk);
        rgb = {r, g, b};
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 0; pal = 0; scandouble = 0; mode = 2'd0; col = 2'd1;
    repeat (3) @(negedge clk);
    total++;
    if ({ce_pix, HBlank, HSync, VBlank, VSync} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 00000", {ce_pix, HBlank, HSync, VBlank, VSync});
    end
    total++;
    if (hc !== '0 || vc !== '0) begin
      bad++; $display("FAIL reset_counters: got hc=%0d vc=%0d want 0 0", hc, vc);
    end
    total++;
    if (frame !== 8'd0) begin
      bad++; $display("FAIL reset_frame: got %0d want 0", frame);
    end
    total++;
    if ({r, g, b} !== 24'h0) begin
      bad++; $display("FAIL reset_rgb: got %h want 000000", {r, g, b});
    end
  endtask

  task automatic test_ce_timing();
    int n, m;
    @(negedge clk);
    reset_n = 1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce_pix) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != CE) begin
      bad++; $display("FAIL first_ce: got %0d clks want %0d", n, CE);
    end
    total++;
    if (hc !== '0) begin
      bad++; $display("FAIL hc_at_first_ce: got %0d want 0", hc);
    end
    m = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce_pix) begin
        m = i;
        break;
      end
    end
    total++;
    if (m != CE) begin
      bad++; $display("FAIL ce_period: got %0d want %0d", m, CE);
    end
    total++;
    if (hc !== 10'd1) begin
      bad++; $display("FAIL hc_at_second_ce: got %0d want 1", hc);
    end
  endtask

  // Frame 0 uses the reset tint (white); col=1 is latched for frame 1.
  task automatic test_noise();
    logic [31:0] lfsr;
    logic [7:0]  n, er, eg, eb;
    bit          blk, white;
    int          ces;
    mode = 2'd0; col = 2'd1;
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
    lfsr = 32'h1;
    ces = 0;
    for (int i = 0; i < 6000 && ces < int'(2 * HT * VTN); i++) begin
      @(negedge clk);
      if (ce_pix) begin
        white = (frame == 8'd0);
        blk   = (hc >= HA) || (vc >= VAN);
        n     = lfsr[7:0];
        lfsr  = ref_lfsr(lfsr);
        ces++;
        er = blk ? 8'h00 : n;
        eg = (blk || !white) ? 8'h00 : n;
        eb = (blk || !white) ? 8'h00 : n;
        @(negedge clk);
        total++;
        if ({r, g, b} !== {er, eg, eb}) begin
          bad++; $display("FAIL noise_ce%0d: got %h want %h", ces, {r, g, b}, {er, eg, eb});
        end
      end
    end
    total++;
    if (ces != int'(2 * HT * VTN)) begin
      bad++; $display("FAIL noise_ce_count: got %0d want %0d", ces, 2 * HT * VTN);
    end
  endtask

  task automatic test_frame_ntsc();
    int clks, ces, maxv, vsmin, vsmax, errs;
    bit ok, okw;
    wait_frame_change(okw);
    scan_frame(VAN, VAN + VSO, VAN + VSO + VSL, clks, ces, maxv, vsmin, vsmax, errs, ok);
    total++;
    if (!ok || !okw) begin
      bad++; $display("FAIL ntsc_timeout: got ok=%0d/%0d want 1/1", okw, ok);
    end
    total++;
    if (clks != int'(HT * VTN * CE)) begin
      bad++; $display("FAIL ntsc_clks: got %0d want %0d", clks, HT * VTN * CE);
    end
    total++;
    if (ces != int'(HT * VTN)) begin
      bad++; $display("FAIL ntsc_ces: got %0d want %0d", ces, HT * VTN);
    end
    total++;
    if (maxv != 13) begin
      bad++; $display("FAIL ntsc_maxv: got %0d want 13", maxv);
    end
    total++;
    if (vsmin != 11 || vsmax != 12) begin
      bad++; $display("FAIL ntsc_vsync: got %0d..%0d want 11..12", vsmin, vsmax);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL ntsc_strobes: got %0d bad samples want 0", errs);
    end
    total++;
    if (frame !== 8'd4 || hc !== '0 || vc !== '0) begin
      bad++; $display("FAIL ntsc_wrap: got f=%0d hc=%0d vc=%0d want 4 0 0", frame, hc, vc);
    end
  endtask

  task automatic test_pal();
    int clks, ces, maxv, vsmin, vsmax, errs;
    bit ok;
    pal = 1;
    scan_frame(VAN, VAN + VSO, VAN + VSO + VSL, clks, ces, maxv, vsmin, vsmax, errs, ok);
    total++;
    if (!ok || clks != int'(HT * VTN * CE) || maxv != 13 || errs != 0) begin
      bad++; $display("FAIL pal_held_frame: got clks=%0d maxv=%0d errs=%0d want %0d 13 0",
                      clks, maxv, errs, HT * VTN * CE);
    end
    scan_frame(VAP, VAP + VSO, VAP + VSO + VSL, clks, ces, maxv, vsmin, vsmax, errs, ok);
    total++;
    if (!ok || clks != int'(HT * VTP * CE)) begin
      bad++; $display("FAIL pal_clks: got %0d want %0d", clks, HT * VTP * CE);
    end
    total++;
    if (maxv != 17) begin
      bad++; $display("FAIL pal_maxv: got %0d want 17", maxv);
    end
    total++;
    if (vsmin != 13 || vsmax != 14) begin
      bad++; $display("FAIL pal_vsync: got %0d..%0d want 13..14", vsmin, vsmax);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL pal_strobes: got %0d bad samples want 0", errs);
    end
  endtask

  task automatic test_scandouble();
    int clks, ces, maxv, vsmin, vsmax, errs, m;
    bit ok, okw;
    pal = 0; scandouble = 1;
    wait_frame_change(okw);
    scan_frame(2 * VAN, 2 * (VAN + VSO), 2 * (VAN + VSO + VSL), clks, ces, maxv, vsmin, vsmax,
               errs, ok);
    total++;
    if (!ok || !okw || clks != int'(HT * 2 * VTN * CE / 2)) begin
      bad++; $display("FAIL sd_clks: got %0d want %0d", clks, HT * 2 * VTN * CE / 2);
    end
    total++;
    if (ces != int'(HT * 2 * VTN)) begin
      bad++; $display("FAIL sd_ces: got %0d want %0d", ces, HT * 2 * VTN);
    end
    total++;
    if (maxv != 27) begin
      bad++; $display("FAIL sd_maxv: got %0d want 27", maxv);
    end
    total++;
    if (vsmin != 22 || vsmax != 25) begin
      bad++; $display("FAIL sd_vsync: got %0d..%0d want 22..25", vsmin, vsmax);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL sd_strobes: got %0d bad samples want 0", errs);
    end
    for (int i = 0; i < 10 && !ce_pix; i++) @(negedge clk);
    m = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ce_pix) begin
        m = i;
        break;
      end
    end
    total++;
    if (m != int'(CE / 2)) begin
      bad++; $display("FAIL sd_ce_period: got %0d want %0d", m, CE / 2);
    end
  endtask

  task automatic test_bars();
    int          tv [5] = '{5, 5, 5, 5, 5};
    int          th [5] = '{0, 4, 13, 28, 33};
    logic [23:0] te [5] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000, 24'h000000};
    logic [23:0] got;
    bit ok;
    scandouble = 0; mode = 2'd1; col = 2'd0;
    wait_frame_change(ok);
    for (int k = 0; k < 5; k++) begin
      pix_at(tv[k], th[k], got, ok);
      total++;
      if (!ok || got !== te[k]) begin
        bad++; $display("FAIL bars_v%0d_h%0d: got %h ok=%0d want %h", tv[k], th[k], got, ok, te[k]);
      end
    end
  endtask

  task automatic test_grid();
    int          tv [5] = '{0, 3, 3, 3, 3};
    int          th [5] = '{5, 0, 5, 16, 32};
    logic [23:0] te [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    logic [23:0] got;
    bit ok;
    mode = 2'd2;
    wait_frame_change(ok);
    for (int k = 0; k < 5; k++) begin
      pix_at(tv[k], th[k], got, ok);
      total++;
      if (!ok || got !== te[k]) begin
        bad++; $display("FAIL grid_v%0d_h%0d: got %h ok=%0d want %h", tv[k], th[k], got, ok, te[k]);
      end
    end
  endtask

  // New mode must not take effect until the next frame starts.
  task automatic test_solid();
    int          tv [4] = '{2, 2, 11, 13};
    int          th [4] = '{5, 31, 5, 20};
    logic [23:0] te [4] = '{24'h00FF00, 24'h00FF00, 24'h000000, 24'h000000};
    logic [23:0] got;
    bit ok;
    mode = 2'd3; col = 2'd2;
    pix_at(5, 5, got, ok);
    total++;
    if (!ok || got !== 24'h000000) begin
      bad++; $display("FAIL solid_not_yet_latched: got %h ok=%0d want 000000", got, ok);
    end
    wait_frame_change(ok);
    for (int k = 0; k < 4; k++) begin
      pix_at(tv[k], th[k], got, ok);
      total++;
      if (!ok || got !== te[k]) begin
        bad++; $display("FAIL solid_v%0d_h%0d: got %h ok=%0d want %h", tv[k], th[k], got, ok, te[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    bit ok;
    int n;
    col = 2'd0;
    wait_frame_change(ok);
    pix_at(3, 20, got, ok);
    total++;
    if (!ok || got !== 24'hFFFFFF) begin
      bad++; $display("FAIL pre_reset_pixel: got %h ok=%0d want ffffff", got, ok);
    end
    #2 reset_n = 0;
    #1;
    total++;
    if (hc !== '0 || vc !== '0 || frame !== 8'd0) begin
      bad++; $display("FAIL midreset_counters: got hc=%0d vc=%0d f=%0d want 0 0 0", hc, vc, frame);
    end
    total++;
    if ({ce_pix, HBlank, HSync, VBlank, VSync, r, g, b} !== 29'h0) begin
      bad++; $display("FAIL midreset_outputs: got %b %h want 0", {ce_pix, HBlank, HSync, VBlank, VSync},
                      {r, g, b});
    end
    @(negedge clk);
    reset_n = 1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce_pix) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != CE || hc !== '0) begin
      bad++; $display("FAIL midreset_first_ce: got %0d clks hc=%0d want %0d 0", n, hc, CE);
    end
    @(negedge clk);
    total++;
    if ({r, g, b} !== 24'h010101) begin
      bad++; $display("FAIL lfsr_restart0: got %h want 010101", {r, g, b});
    end
    for (int i = 0; i < 10 && !ce_pix; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if ({r, g, b} !== 24'h030303) begin
      bad++; $display("FAIL lfsr_restart1: got %h want 030303", {r, g, b});
    end
  endtask

  initial begin
    test_reset();
    test_ce_timing();
    test_noise();
    test_frame_ntsc();
    test_pal();
    test_scandouble();
    test_bars();
    test_grid();
    test_solid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
